// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: drives the PC register's hold/redirect inputs
// and the IF/ID and ID/EX stall/flush controls. It arbitrates between traps,
// trap returns and EX-resolved branches, and holds a redirect until the
// instruction memory accepts it. It also sleeps in HALT after a WFI retires.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_ready                 fetch accepted this cycle
//   load_use_hazard            ID requests a one-cycle bubble
//   ex_redirect / ex_target    EX-resolved branch or jump
//   trap_req / trap_vec        exception or interrupt entry
//   mret_req / mepc            trap return
//   halt_req, wake             WFI retired / interrupt pending
//   keep_pc, branch_op,
//   branch_target              PC register hold/redirect controls (combinational)
//   stall_if_id, flush_if_id,
//   flush_id_ex                pipeline register controls (combinational)
//   state                      debug view of the controller state
//   redirect_cnt, stall_cnt    event counters (registered)
module fetch_redirect_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_ready,
  input  logic        load_use_hazard,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  input  logic        trap_req,
  input  logic [31:0] trap_vec,
  input  logic        mret_req,
  input  logic [31:0] mepc,
  input  logic        halt_req,
  input  logic        wake,
  output logic        keep_pc,
  output logic        branch_op,
  output logic [31:0] branch_target,
  output logic        stall_if_id,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic [1:0]  state,
  output logic [15:0] redirect_cnt,
  output logic [31:0] stall_cnt
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned RCNT_W = 16;
  localparam int unsigned SCNT_W = 32;

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    HOLD_REDIR = 2'b01,
    HALT       = 2'b10,
    ILLEGAL    = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   tgt_q, tgt_d;
  logic [RCNT_W-1:0]   redirect_cnt_q, redirect_cnt_d;
  logic [SCNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic                redir_any;
  logic [ADDR_W-1:0]   sel_tgt;
  logic [ADDR_W-1:0]   trap_tgt;
  logic [ADDR_W-1:0]   hold_tgt;

  // Fixed-priority redirect source select; targets are always word aligned.
  always_comb begin
    redir_any = trap_req | mret_req | ex_redirect;
    trap_tgt  = {trap_vec[ADDR_W-1:2], 2'b00};
    if (trap_req) begin
      sel_tgt = trap_tgt;
    end else if (mret_req) begin
      sel_tgt = {mepc[ADDR_W-1:2], 2'b00};
    end else begin
      sel_tgt = {ex_target[ADDR_W-1:2], 2'b00};
    end
    // A trap arriving while a redirect is pending supersedes it.
    hold_tgt = trap_req ? trap_tgt : tgt_q;
  end

  // Next-state and combinational pipeline controls.
  always_comb begin
    state_d       = state_q;
    tgt_d         = tgt_q;
    keep_pc       = 1'b0;
    branch_op     = 1'b0;
    branch_target = '0;
    stall_if_id   = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;

    case (state_q)
      RUN: begin
        if (redir_any) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          if (imem_ready) begin
            branch_op     = 1'b1;
            branch_target = sel_tgt;
          end else begin
            keep_pc = 1'b1;
            tgt_d   = sel_tgt;
            state_d = HOLD_REDIR;
          end
        end else begin
          if (load_use_hazard) begin
            keep_pc     = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end
          if (!imem_ready) begin
            keep_pc     = 1'b1;
            stall_if_id = 1'b1;
          end
          if (halt_req) begin
            state_d = HALT;
          end
        end
      end

      HOLD_REDIR: begin
        flush_if_id = 1'b1;
        if (imem_ready) begin
          branch_op     = 1'b1;
          branch_target = hold_tgt;
          state_d       = RUN;
        end else begin
          keep_pc = 1'b1;
          tgt_d   = hold_tgt;
        end
      end

      HALT: begin
        // Only a trap leaves HALT with a redirect; it behaves as in RUN.
        if (trap_req) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          if (imem_ready) begin
            branch_op     = 1'b1;
            branch_target = trap_tgt;
            state_d       = RUN;
          end else begin
            keep_pc = 1'b1;
            tgt_d   = trap_tgt;
            state_d = HOLD_REDIR;
          end
        end else begin
          keep_pc     = 1'b1;
          flush_if_id = 1'b1;
          if (wake) begin
            state_d = RUN;
          end
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Saturating redirect counter, wrapping stall counter.
  always_comb begin
    redirect_cnt_d = redirect_cnt_q;
    if (branch_op && (redirect_cnt_q != {RCNT_W{1'b1}})) begin
      redirect_cnt_d = redirect_cnt_q + RCNT_W'(1);
    end
    stall_cnt_d = stall_cnt_q + SCNT_W'(keep_pc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      tgt_q          <= '0;
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      tgt_q          <= tgt_d;
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign state        = state_q;
  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed scenarios plus randomized traffic
// checked against a rule-level reference model.
module tb_fetch_redirect_ctrl;

  localparam logic [1:0]  ST_RUN  = 2'b00;
  localparam logic [1:0]  ST_HOLD = 2'b01;
  localparam logic [1:0]  ST_HALT = 2'b10;
  localparam logic [31:0] ALIGN   = 32'hFFFF_FFFC;

  logic        clk, rst_n;
  logic        imem_ready, load_use_hazard, ex_redirect, trap_req, mret_req;
  logic        halt_req, wake;
  logic [31:0] ex_target, trap_vec, mepc;
  logic        keep_pc, branch_op, stall_if_id, flush_if_id, flush_id_ex;
  logic [31:0] branch_target, stall_cnt;
  logic [1:0]  state;
  logic [15:0] redirect_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [1:0]  m_state;
  logic [31:0] m_lat;
  logic [15:0] m_rcnt;
  logic [31:0] m_scnt;
  // Model expectations for the current cycle
  logic        e_keep, e_bop, e_stall, e_fif, e_fex;
  logic [31:0] e_tgt, e_lat_next;
  logic [1:0]  e_next;

  fetch_redirect_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .imem_ready(imem_ready), .load_use_hazard(load_use_hazard),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .trap_req(trap_req), .trap_vec(trap_vec),
    .mret_req(mret_req), .mepc(mepc),
    .halt_req(halt_req), .wake(wake),
    .keep_pc(keep_pc), .branch_op(branch_op), .branch_target(branch_target),
    .stall_if_id(stall_if_id), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .state(state), .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected behaviour of the current cycle, phrased as the controller's rules.
  task automatic model_eval();
    logic        take;
    logic [31:0] dest;
    {e_keep, e_bop, e_stall, e_fif, e_fex} = 5'b0;
    e_tgt = 32'h0; e_next = m_state; e_lat_next = m_lat;
    take = 1'b0; dest = 32'h0;
    if (m_state == ST_RUN) begin
      take = trap_req || mret_req || ex_redirect;
      dest = trap_req ? trap_vec : (mret_req ? mepc : ex_target);
    end else if (m_state == ST_HALT) begin
      take = trap_req;
      dest = trap_vec;
    end
    dest = dest & ALIGN;
    if (m_state == ST_HOLD) begin
      e_fif = 1'b1;
      if (trap_req) e_lat_next = trap_vec & ALIGN;
      if (imem_ready) begin
        e_bop = 1'b1; e_tgt = e_lat_next; e_next = ST_RUN;
      end else begin
        e_keep = 1'b1;
      end
    end else if (take) begin
      e_fif = 1'b1; e_fex = 1'b1;
      if (imem_ready) begin
        e_bop = 1'b1; e_tgt = dest; e_next = ST_RUN;
      end else begin
        e_keep = 1'b1; e_lat_next = dest; e_next = ST_HOLD;
      end
    end else if (m_state == ST_HALT) begin
      e_keep = 1'b1; e_fif = 1'b1;
      if (wake) e_next = ST_RUN;
    end else begin
      if (load_use_hazard) begin e_keep = 1'b1; e_stall = 1'b1; e_fex = 1'b1; end
      if (!imem_ready)     begin e_keep = 1'b1; e_stall = 1'b1; end
      if (halt_req) e_next = ST_HALT;
    end
  endtask

  task automatic model_reset();
    m_state = ST_RUN; m_lat = 32'h0; m_rcnt = 16'h0; m_scnt = 32'h0;
  endtask

  // Advance model and DUT by one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    model_eval();
    if (e_bop && m_rcnt != 16'hFFFF) m_rcnt = m_rcnt + 16'd1;
    if (e_keep) m_scnt = m_scnt + 32'd1;
    m_state = e_next;
    m_lat   = e_lat_next;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_ready = 1'b1; load_use_hazard = 1'b0; ex_redirect = 1'b0;
    trap_req = 1'b0; mret_req = 1'b0; halt_req = 1'b0; wake = 1'b0;
    ex_target = 32'h0; trap_vec = 32'h0; mepc = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    #2;
    n_vec++;
    if ({state, redirect_cnt, stall_cnt} !== 50'h0) begin
      n_err++;
      $display("FAIL reset_regs got state=%b rcnt=%0d scnt=%0d exp all 0", state, redirect_cnt, stall_cnt);
    end
    n_vec++;
    if ({keep_pc, branch_op, stall_if_id, flush_if_id, flush_id_ex} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outs got %b exp 00000", {keep_pc, branch_op, stall_if_id, flush_if_id, flush_id_ex});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_redirect_basic();
    clear_inputs();
    ex_redirect = 1'b1; ex_target = 32'h0000_0103;
    @(negedge clk);
    n_vec++;
    if ({keep_pc, branch_op, stall_if_id, flush_if_id, flush_id_ex} !== 5'b01011 || branch_target !== 32'h100) begin
      n_err++;
      $display("FAIL redirect_basic got ctl=%b tgt=%h exp ctl=01011 tgt=00000100",
               {keep_pc, branch_op, stall_if_id, flush_if_id, flush_id_ex}, branch_target);
    end
    n_vec++;
    if (redirect_cnt !== 16'd0) begin
      n_err++; $display("FAIL redirect_cnt_before got %0d exp 0", redirect_cnt);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    n_vec++;
    if (redirect_cnt !== 16'd1) begin
      n_err++; $display("FAIL redirect_cnt_after got %0d exp 1", redirect_cnt);
    end
    tick();
  endtask

  task automatic test_priority();
    clear_inputs();
    trap_req = 1'b1; trap_vec = 32'h8000_0000;
    mret_req = 1'b1; mepc = 32'h0000_1237;
    ex_redirect = 1'b1; ex_target = 32'h0000_5678;
    load_use_hazard = 1'b1;
    @(negedge clk);
    n_vec++;
    if (branch_target !== 32'h8000_0000 || keep_pc !== 1'b0 || stall_if_id !== 1'b0 || branch_op !== 1'b1) begin
      n_err++;
      $display("FAIL prio_trap got tgt=%h keep=%b stall=%b bop=%b exp 80000000/0/0/1",
               branch_target, keep_pc, stall_if_id, branch_op);
    end
    tick();
    trap_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if (branch_target !== 32'h0000_1234) begin
      n_err++; $display("FAIL prio_mret got %h exp 00001234", branch_target);
    end
    tick();
    mret_req = 1'b0; halt_req = 1'b1;
    @(negedge clk);
    n_vec++;
    if (branch_target !== 32'h0000_5678 || keep_pc !== 1'b0) begin
      n_err++; $display("FAIL prio_ex got tgt=%h keep=%b exp 00005678/0", branch_target, keep_pc);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    n_vec++;
    if (state !== ST_RUN) begin
      n_err++; $display("FAIL prio_no_halt got state=%b exp 00", state);
    end
    tick();
  endtask

  task automatic test_hold_trap();
    do_reset();
    imem_ready = 1'b0; ex_redirect = 1'b1; ex_target = 32'h200; trap_vec = 32'h40;
    for (int i = 0; i < 3; i++) begin
      trap_req = (i == 1);
      @(negedge clk);
      n_vec++;
      if (keep_pc !== 1'b1 || branch_op !== 1'b0 || state !== ((i == 0) ? ST_RUN : ST_HOLD)) begin
        n_err++;
        $display("FAIL hold_cycle%0d got keep=%b bop=%b state=%b exp keep=1 bop=0", i, keep_pc, branch_op, state);
      end
      tick();
    end
    trap_req = 1'b0; imem_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (branch_op !== 1'b1 || branch_target !== 32'h40 || keep_pc !== 1'b0 || flush_if_id !== 1'b1) begin
      n_err++;
      $display("FAIL hold_release got bop=%b tgt=%h keep=%b fif=%b exp 1/00000040/0/1",
               branch_op, branch_target, keep_pc, flush_if_id);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    n_vec++;
    if (state !== ST_RUN || stall_cnt !== 32'd3) begin
      n_err++; $display("FAIL hold_after got state=%b scnt=%0d exp 00/3", state, stall_cnt);
    end
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    load_use_hazard = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({keep_pc, branch_op, stall_if_id, flush_if_id, flush_id_ex} !== 5'b10101) begin
      n_err++;
      $display("FAIL load_use got %b exp 10101", {keep_pc, branch_op, stall_if_id, flush_if_id, flush_id_ex});
    end
    tick();
    load_use_hazard = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({keep_pc, branch_op, stall_if_id, flush_if_id, flush_id_ex} !== 5'b00000) begin
      n_err++;
      $display("FAIL load_use_next got %b exp 00000", {keep_pc, branch_op, stall_if_id, flush_if_id, flush_id_ex});
    end
    tick();
  endtask

  task automatic test_halt();
    clear_inputs();
    halt_req = 1'b1;
    @(negedge clk);
    n_vec++;
    if (keep_pc !== 1'b0 || state !== ST_RUN) begin
      n_err++; $display("FAIL halt_entry got keep=%b state=%b exp 0/00", keep_pc, state);
    end
    tick();
    halt_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ex_redirect = (i == 1); mret_req = (i == 2); ex_target = 32'h900; mepc = 32'hA00;
      @(negedge clk);
      n_vec++;
      if (state !== ST_HALT || keep_pc !== 1'b1 || branch_op !== 1'b0 || flush_if_id !== 1'b1 || branch_target !== 32'h0) begin
        n_err++;
        $display("FAIL halt_cycle%0d got state=%b keep=%b bop=%b tgt=%h exp 10/1/0/0", i, state, keep_pc, branch_op, branch_target);
      end
      tick();
    end
    clear_inputs();
    wake = 1'b1;
    @(negedge clk);
    n_vec++;
    if (keep_pc !== 1'b1 || state !== ST_HALT) begin
      n_err++; $display("FAIL wake_cycle got keep=%b state=%b exp 1/10", keep_pc, state);
    end
    tick();
    wake = 1'b0;
    @(negedge clk);
    n_vec++;
    if (state !== ST_RUN || keep_pc !== 1'b0) begin
      n_err++; $display("FAIL wake_after got state=%b keep=%b exp 00/0", state, keep_pc);
    end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0; trap_req = 1'b1; trap_vec = 32'h0000_3001;
    @(negedge clk);
    n_vec++;
    if (branch_op !== 1'b1 || branch_target !== 32'h3000 || keep_pc !== 1'b0 || flush_id_ex !== 1'b1) begin
      n_err++;
      $display("FAIL halt_trap got bop=%b tgt=%h keep=%b fex=%b exp 1/00003000/0/1", branch_op, branch_target, keep_pc, flush_id_ex);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    n_vec++;
    if (state !== ST_RUN) begin
      n_err++; $display("FAIL halt_trap_exit got state=%b exp 00", state);
    end
    tick();
  endtask

  task automatic test_reset_mid_hold();
    clear_inputs();
    imem_ready = 1'b0; ex_redirect = 1'b1; ex_target = 32'h200;
    tick();
    ex_redirect = 1'b0;
    @(negedge clk);
    n_vec++;
    if (state !== ST_HOLD) begin
      n_err++; $display("FAIL mid_hold_state got %b exp 01", state);
    end
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if ({state, redirect_cnt, stall_cnt} !== 50'h0) begin
      n_err++;
      $display("FAIL async_reset got state=%b rcnt=%0d scnt=%0d exp all 0", state, redirect_cnt, stall_cnt);
    end
    imem_ready = 1'b1;
    #1;
    n_vec++;
    if (branch_op !== 1'b0 || keep_pc !== 1'b0) begin
      n_err++; $display("FAIL in_reset_outs got bop=%b keep=%b exp 0/0", branch_op, keep_pc);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (branch_op !== 1'b0 || keep_pc !== 1'b0 || state !== ST_RUN) begin
      n_err++; $display("FAIL post_reset got bop=%b keep=%b state=%b exp 0/0/00", branch_op, keep_pc, state);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      imem_ready      = ($urandom_range(0, 9) < 7);
      load_use_hazard = ($urandom_range(0, 9) < 2);
      ex_redirect     = ($urandom_range(0, 9) < 2);
      trap_req        = ($urandom_range(0, 9) < 1);
      mret_req        = ($urandom_range(0, 9) < 1);
      halt_req        = ($urandom_range(0, 9) < 1);
      wake            = ($urandom_range(0, 9) < 3);
      ex_target = $urandom; trap_vec = $urandom; mepc = $urandom;
      @(negedge clk);
      model_eval();
      n_vec++;
      if ({keep_pc, branch_op, stall_if_id, flush_if_id, flush_id_ex} !== {e_keep, e_bop, e_stall, e_fif, e_fex}) begin
        n_err++;
        $display("FAIL rnd%0d_ctl got %b exp %b", i, {keep_pc, branch_op, stall_if_id, flush_if_id, flush_id_ex},
                 {e_keep, e_bop, e_stall, e_fif, e_fex});
      end
      n_vec++;
      if (branch_target !== e_tgt) begin
        n_err++; $display("FAIL rnd%0d_tgt got %h exp %h", i, branch_target, e_tgt);
      end
      n_vec++;
      if (state !== m_state) begin
        n_err++; $display("FAIL rnd%0d_state got %b exp %b", i, state, m_state);
      end
      n_vec++;
      if (redirect_cnt !== m_rcnt || stall_cnt !== m_scnt) begin
        n_err++;
        $display("FAIL rnd%0d_cnt got r=%0d s=%0d exp r=%0d s=%0d", i, redirect_cnt, stall_cnt, m_rcnt, m_scnt);
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_redirect_basic();
    test_priority();
    test_hold_trap();
    test_load_use();
    test_halt();
    test_reset_mid_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
